// File: rtl/data_memory_access_unit_pkg.sv
// Shared MIPS instruction codes, access-unit FSM states and memory-opcode classification helpers.
package data_memory_access_unit_pkg;

  typedef enum logic [6:0] {
    InstLb  = 7'd42,
    InstLbu = 7'd43,
    InstLh  = 7'd44,
    InstLhu = 7'd45,
    InstLw  = 7'd47,
    InstLwl = 7'd48,
    InstLwr = 7'd49,
    InstSb  = 7'd50,
    InstSh  = 7'd51,
    InstSw  = 7'd52
  } instcode_t;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

  function automatic logic is_mem_code(logic [6:0] code);
    case (code)
      InstLb, InstLbu, InstLh, InstLhu, InstLw,
      InstLwl, InstLwr, InstSb, InstSh, InstSw: is_mem_code = 1'b1;
      default:                                  is_mem_code = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(instcode_t code);
    is_store = (code == InstSb) || (code == InstSh) || (code == InstSw);
  endfunction

  // LWL/LWR are unaligned by design, so only halfword/word accesses can fault.
  function automatic logic is_misaligned(instcode_t code, logic [1:0] offset);
    case (code)
      InstLh, InstLhu, InstSh: is_misaligned = offset[0];
      InstLw, InstSw:          is_misaligned = (offset != 2'b00);
      default:                 is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_access_unit_if.sv
// Pipeline request/response and Avalon-MM data-bus signals of the data memory access unit.
interface data_memory_access_unit_if;
  logic        start;
  logic [6:0]  instruction_code;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] rt_old;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        address_error;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    input  start, instruction_code, address, store_data, rt_old, avm_readdata, avm_waitrequest,
    output stall, done, load_data, address_error,
    output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
  );

  modport slave (
    output start, instruction_code, address, store_data, rt_old, avm_readdata, avm_waitrequest,
    input  stall, done, load_data, address_error,
    input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
  );
endinterface

// File: rtl/data_memory_access_unit_load_formatter.sv
// Combinational load alignment: byte/half extraction with extension and LWL/LWR merge with rt.
module data_memory_access_unit_load_formatter
  import data_memory_access_unit_pkg::*;
(
  input  instcode_t   code_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  input  logic [31:0] rt_old_i,
  output logic [31:0] load_data_o
);

  logic [4:0]  shamt;
  logic [31:0] word_sh;

  assign shamt   = {offset_i, 3'b000};
  assign word_sh = word_i >> shamt;

  always_comb begin
    load_data_o = word_i;
    case (code_i)
      InstLb:  load_data_o = {{24{word_sh[7]}}, word_sh[7:0]};
      InstLbu: load_data_o = {24'h0, word_sh[7:0]};
      InstLh:  load_data_o = {{16{word_sh[15]}}, word_sh[15:0]};
      InstLhu: load_data_o = {16'h0, word_sh[15:0]};
      // LWL fills the upper lanes from memory, LWR the lower; rt keeps the rest.
      InstLwl: load_data_o = (word_i << (5'd24 - shamt)) | (rt_old_i & (32'h00FF_FFFF >> shamt));
      InstLwr: load_data_o = word_sh | (rt_old_i & ~(32'hFFFF_FFFF >> shamt));
      default: load_data_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_memory_access_unit.sv
// Memory-stage access unit: latches a load/store request, runs one Avalon-MM cycle and stalls
// the pipeline until it completes, then returns the formatted load result with a done pulse.
module data_memory_access_unit
  import data_memory_access_unit_pkg::*;
(
  input logic                       clk_i,
  input logic                       rst_i,
  data_memory_access_unit_if.master bus_io
);

  state_t      state_q, state_d;
  instcode_t   code_q, code_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rt_old_q, rt_old_d;
  logic [31:0] load_data_q, load_data_d;
  logic        err_q, err_d;

  logic        req_valid;
  logic        in_access;
  instcode_t   req_code;
  logic [31:0] fmt_data;
  logic [3:0]  byteenable;
  logic [31:0] writedata;

  assign req_valid = bus_io.start && is_mem_code(bus_io.instruction_code);
  assign req_code  = instcode_t'(bus_io.instruction_code);
  assign in_access = (state_q == StAccess);

  data_memory_access_unit_load_formatter u_load_formatter (
    .code_i      (code_q),
    .offset_i    (addr_q[1:0]),
    .word_i      (bus_io.avm_readdata),
    .rt_old_i    (rt_old_q),
    .load_data_o (fmt_data)
  );

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rt_old_d    = rt_old_q;
    load_data_d = load_data_q;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          code_d   = req_code;
          addr_d   = bus_io.address;
          wdata_d  = bus_io.store_data;
          rt_old_d = bus_io.rt_old;
          if (is_misaligned(req_code, bus_io.address[1:0])) begin
            err_d       = 1'b1;
            load_data_d = '0;
            state_d     = StDone;
          end else begin
            err_d   = 1'b0;
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (!bus_io.avm_waitrequest) begin
          load_data_d = is_store(code_q) ? '0 : fmt_data;
          state_d     = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus fields are derived from the latched request, so they stay stable through waitrequest.
  always_comb begin
    byteenable = 4'b0000;
    writedata  = '0;
    if (in_access) begin
      case (code_q)
        InstSb: begin
          byteenable = 4'b0001 << addr_q[1:0];
          writedata  = {4{wdata_q[7:0]}};
        end
        InstSh: begin
          byteenable = 4'b0011 << addr_q[1:0];
          writedata  = {2{wdata_q[15:0]}};
        end
        InstSw: begin
          byteenable = 4'b1111;
          writedata  = wdata_q;
        end
        default: byteenable = 4'b1111;
      endcase
    end
  end

  assign bus_io.stall          = ((state_q == StIdle) && req_valid) || in_access;
  assign bus_io.done           = (state_q == StDone);
  assign bus_io.address_error  = (state_q == StDone) && err_q;
  assign bus_io.load_data      = load_data_q;
  assign bus_io.avm_address    = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_io.avm_read       = in_access && !is_store(code_q);
  assign bus_io.avm_write      = in_access && is_store(code_q);
  assign bus_io.avm_byteenable = byteenable;
  assign bus_io.avm_writedata  = writedata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      code_q      <= InstLb;
      addr_q      <= '0;
      wdata_q     <= '0;
      rt_old_q    <= '0;
      load_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rt_old_q    <= rt_old_d;
      load_data_q <= load_data_d;
      err_q       <= err_d;
    end
  end

endmodule
